// File: rtl/simon_pkg.sv
// Shared constants for the Simon Says up/down counter slice.
// Direction encodings, wrap/saturate mode selectors and the default counter width.
package simon_pkg;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    localparam int DEFAULT_WIDTH = 8;

endpackage : simon_pkg

// File: rtl/simon_cnt_next.sv
// Combinational next-count and boundary detect for the up/down counter.
// Works in WIDTH+1 bits so a full-range MAX_COUNT never overflows the compare.
module simon_cnt_next
    import simon_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_COUNT = (2**WIDTH) - 1,
    parameter int SATURATE  = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count_q,
    input  logic             dir_up,
    output logic [WIDTH-1:0] next_count,
    output logic             at_boundary
);

    localparam logic [WIDTH:0]   MAX_EXT = MAX_COUNT[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_W   = MAX_COUNT[WIDTH-1:0];

    logic [WIDTH:0] cnt_ext;

    assign cnt_ext = {1'b0, count_q};

    // Boundaries come from comparisons only; the carry of the +/-1 is discarded.
    always_comb begin
        next_count  = count_q;
        at_boundary = 1'b0;
        if (dir_up == DIR_UP) begin
            at_boundary = (cnt_ext == MAX_EXT);
            if (!at_boundary) begin
                next_count = WIDTH'(cnt_ext + (WIDTH + 1)'(1));
            end else if (SATURATE == MODE_SAT) begin
                next_count = count_q;
            end else begin
                next_count = '0;
            end
        end else begin
            at_boundary = (cnt_ext == '0);
            if (!at_boundary) begin
                next_count = WIDTH'(cnt_ext - (WIDTH + 1)'(1));
            end else if (SATURATE == MODE_SAT) begin
                next_count = count_q;
            end else begin
                next_count = MAX_W;
            end
        end
    end

endmodule : simon_cnt_next

// File: rtl/simon_updown_counter.sv
// Parametrised up/down modulo counter with load clamp, terminal-count pulse,
// registered compare flag and an explicit output-enable vector for the pad bus.
module simon_updown_counter
    import simon_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_COUNT = (2**WIDTH) - 1,
    parameter int SATURATE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             dir_up,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             oe,
    output logic [WIDTH-1:0] count_q,
    output logic [WIDTH-1:0] count_out,
    output logic [WIDTH-1:0] count_oe,
    output logic             tc,
    output logic             match
);

    if (WIDTH < 2 || WIDTH > 16 || MAX_COUNT < 1 || MAX_COUNT > (2**WIDTH) - 1) begin : g_bad_params
        $fatal(1, "simon_updown_counter: illegal WIDTH/MAX_COUNT combination");
    end

    localparam logic [WIDTH:0]   MAX_EXT = MAX_COUNT[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_W   = MAX_COUNT[WIDTH-1:0];

    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             match_d;
    logic             tc_q;
    logic             match_q;
    logic [WIDTH-1:0] next_count;
    logic             at_boundary;

    simon_cnt_next #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .SATURATE  (SATURATE)
    ) u_cnt_next (
        .count_q     (count_q),
        .dir_up      (dir_up),
        .next_count  (next_count),
        .at_boundary (at_boundary)
    );

    // Load beats counting; match always looks at the value about to be registered.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = ({1'b0, load_data} > MAX_EXT) ? MAX_W : load_data;
        end else if (clk_en) begin
            count_d = next_count;
            tc_d    = at_boundary;
        end
        match_d = (count_d == cmp_val);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            match_q <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            match_q <= match_d;
        end
    end

    assign tc        = tc_q;
    assign match     = match_q;
    assign count_out = oe ? count_q : '0;
    assign count_oe  = {WIDTH{oe}};

endmodule : simon_updown_counter

// File: tb/tb_simon_updown_counter.sv
// Directed self-checking bench: three counter configurations share one stimulus stream
// (mod-10 wrap, mod-10 saturate, full 8-bit wrap).
module tb_simon_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic       load;
    logic [7:0] load_data;
    logic       dir_up;
    logic [7:0] cmp_val;
    logic       oe;

    logic [7:0] w_count_q, w_count_out, w_count_oe;
    logic       w_tc, w_match;
    logic [7:0] s_count_q, s_count_out, s_count_oe;
    logic       s_tc, s_match;
    logic [7:0] f_count_q, f_count_out, f_count_oe;
    logic       f_tc, f_match;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simon_updown_counter #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(0)) u_wrap9 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .load(load), .load_data(load_data),
        .dir_up(dir_up), .cmp_val(cmp_val), .oe(oe), .count_q(w_count_q),
        .count_out(w_count_out), .count_oe(w_count_oe), .tc(w_tc), .match(w_match)
    );

    simon_updown_counter #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(1)) u_sat9 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .load(load), .load_data(load_data),
        .dir_up(dir_up), .cmp_val(cmp_val), .oe(oe), .count_q(s_count_q),
        .count_out(s_count_out), .count_oe(s_count_oe), .tc(s_tc), .match(s_match)
    );

    simon_updown_counter #(.WIDTH(8), .MAX_COUNT(255), .SATURATE(0)) u_full (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .load(load), .load_data(load_data),
        .dir_up(dir_up), .cmp_val(cmp_val), .oe(oe), .count_q(f_count_q),
        .count_out(f_count_out), .count_oe(f_count_oe), .tc(f_tc), .match(f_match)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic ld, input logic [7:0] ld_data,
                                 input logic up, input logic [7:0] cmp, input logic o);
        rst_n     = r;
        clk_en    = en;
        load      = ld;
        load_data = ld_data;
        dir_up    = up;
        cmp_val   = cmp;
        oe        = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with oe=1 for two cycles, cmp_val=0 must not raise match
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1);
        tick();
        tick();
        checkOutput("rst_count_q",   16'(w_count_q),   16'h00);
        checkOutput("rst_tc",        16'(w_tc),        16'h0);
        checkOutput("rst_match",     16'(w_match),     16'h0);
        checkOutput("rst_count_out", 16'(w_count_out), 16'h00);
        checkOutput("rst_count_oe",  16'(w_count_oe),  16'hFF);
        checkOutput("rst_full_q",    16'(f_count_q),   16'h00);
        oe = 1'b0;
        #1;
        checkOutput("oe0_count_oe",  16'(w_count_oe),  16'h00);
        checkOutput("oe0_count_out", 16'(w_count_out), 16'h00);
        tick();
        checkOutput("rst_oe0_q",     16'(w_count_q),   16'h00);
        checkOutput("rst_oe0_oe",    16'(w_count_oe),  16'h00);

        // Up wrap on mod-10: load 8 then count 9, 0, 1
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd8, 1'b1, 8'd200, 1'b1);
        tick();
        checkOutput("upw_load_q",    16'(w_count_q),   16'd8);
        checkOutput("upw_load_tc",   16'(w_tc),        16'h0);
        checkOutput("upw_count_out", 16'(w_count_out), 16'd8);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd200, 1'b1);
        tick();
        checkOutput("upw_q9",        16'(w_count_q),   16'd9);
        checkOutput("upw_tc9",       16'(w_tc),        16'h0);
        tick();
        checkOutput("upw_q0",        16'(w_count_q),   16'd0);
        checkOutput("upw_tc0",       16'(w_tc),        16'h1);
        checkOutput("ups_q9",        16'(s_count_q),   16'd9);
        checkOutput("ups_tc9",       16'(s_tc),        16'h1);
        tick();
        checkOutput("upw_q1",        16'(w_count_q),   16'd1);
        checkOutput("upw_tc1",       16'(w_tc),        16'h0);
        checkOutput("ups_q9_hold",   16'(s_count_q),   16'd9);
        checkOutput("ups_tc9_again", 16'(s_tc),        16'h1);

        // Down saturate on mod-10: load 1 then four down cycles
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 8'd200, 1'b1);
        tick();
        checkOutput("dns_load_q",    16'(s_count_q),   16'd1);
        checkOutput("dns_load_tc",   16'(s_tc),        16'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd200, 1'b1);
        tick();
        checkOutput("dns_q_1",       16'(s_count_q),   16'd0);
        checkOutput("dns_tc_1",      16'(s_tc),        16'h0);
        tick();
        checkOutput("dns_q_2",       16'(s_count_q),   16'd0);
        checkOutput("dns_tc_2",      16'(s_tc),        16'h1);
        checkOutput("dnw_q_2",       16'(w_count_q),   16'd9);
        checkOutput("dnw_tc_2",      16'(w_tc),        16'h1);
        tick();
        checkOutput("dns_q_3",       16'(s_count_q),   16'd0);
        checkOutput("dns_tc_3",      16'(s_tc),        16'h1);
        checkOutput("dnw_q_3",       16'(w_count_q),   16'd8);
        checkOutput("dnw_tc_3",      16'(w_tc),        16'h0);
        tick();
        checkOutput("dns_q_4",       16'(s_count_q),   16'd0);
        checkOutput("dns_tc_4",      16'(s_tc),        16'h1);

        // Load beats clk_en and clamps; reset beats load
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd15, 1'b0, 8'd200, 1'b1);
        tick();
        checkOutput("clamp_q",       16'(w_count_q),   16'd9);
        checkOutput("clamp_tc",      16'(w_tc),        16'h0);
        checkOutput("clamp_sat_tc",  16'(s_tc),        16'h0);
        checkOutput("noclamp_full",  16'(f_count_q),   16'd15);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd15, 1'b0, 8'd200, 1'b1);
        tick();
        checkOutput("rst_over_load", 16'(w_count_q),   16'd0);
        checkOutput("rst_over_ld_f", 16'(f_count_q),   16'd0);

        // Compare flag counting up from 0 with cmp_val=3, then flip direction
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd3, 1'b1);
        tick();
        checkOutput("cmp_q1",        16'(w_count_q),   16'd1);
        checkOutput("cmp_m1",        16'(w_match),     16'h0);
        tick();
        checkOutput("cmp_m2",        16'(w_match),     16'h0);
        tick();
        checkOutput("cmp_q3",        16'(w_count_q),   16'd3);
        checkOutput("cmp_m3",        16'(w_match),     16'h1);
        checkOutput("cmp_full_m3",   16'(f_match),     16'h1);
        dir_up = 1'b0;
        tick();
        checkOutput("cmp_flip_q",    16'(w_count_q),   16'd2);
        checkOutput("cmp_flip_m",    16'(w_match),     16'h0);
        clk_en = 1'b0;
        tick();
        checkOutput("hold_q",        16'(w_count_q),   16'd2);
        checkOutput("hold_tc",       16'(w_tc),        16'h0);

        // Full-range wrap at 255 in both directions
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd255, 1'b1, 8'd3, 1'b1);
        tick();
        checkOutput("full_load_q",   16'(f_count_q),   16'd255);
        checkOutput("full_clamp_w",  16'(w_count_q),   16'd9);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd3, 1'b1);
        tick();
        checkOutput("full_up_q",     16'(f_count_q),   16'd0);
        checkOutput("full_up_tc",    16'(f_tc),        16'h1);
        dir_up = 1'b0;
        tick();
        checkOutput("full_dn_q",     16'(f_count_q),   16'd255);
        checkOutput("full_dn_tc",    16'(f_tc),        16'h1);
        checkOutput("full_dn_out",   16'(f_count_out), 16'd255);
        oe = 1'b0;
        #1;
        checkOutput("full_oe0_out",  16'(f_count_out), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_simon_updown_counter
